// File: rtl/fetch_unit.sv
// Instruction fetch: requests the word at PC, latches it into IR and presents decode fields.
// Latency: MEM_ACK edge to VALID high is 1 cycle; STALL=0 in hold returns to request on the next edge.
// Backpressure: STALL freezes IR/PC_OUT/VALID while holding; optional watchdog via FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [31:0] MEM_DATA,
    input  logic        MEM_ACK,
    output logic [31:0] PC_OUT,
    output logic [5:0]  OPCODE,
    output logic [4:0]  DIR_A,
    output logic [4:0]  DIR_B,
    output logic [4:0]  DIR_WRA,
    output logic [15:0] IMD,
    output logic        VALID,
    output logic        ERR
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // The watchdog counter is 8 bits wide, so the limit must fit in 1..255.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYC must be in 1..255");
    end

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        mem_rd_q, mem_rd_d;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wdog_cnt_q, wdog_cnt_d;
    logic       retry_q, retry_d;
    logic       err_q, err_d;
`endif

    // Next-state logic: branch redirect wins over everything, then the per-state behaviour.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
`ifdef FETCH_TIMEOUT_EN
        wdog_cnt_d = wdog_cnt_q;
        retry_d    = 1'b0;
        err_d      = err_q;
`endif
        if (BR_TAKEN) begin
            // Any data returned in this cycle belongs to the wrong path and is dropped.
            pc_d    = {BR_TARGET[31:2], 2'b00};
            valid_d = 1'b0;
            state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
            wdog_cnt_d = 8'd0;
`endif
        end else begin
            unique case (state_q)
                S_REQ: begin
`ifdef FETCH_TIMEOUT_EN
                    if (retry_q) begin
                        // Back-off cycle after a timeout: no request is outstanding, so ACK is meaningless.
                        wdog_cnt_d = 8'd0;
                    end else if (MEM_ACK) begin
                        ir_d       = MEM_DATA;
                        pc_out_d   = pc_q;
                        pc_d       = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                        wdog_cnt_d = 8'd0;
                    end else if (wdog_cnt_q == WDOG_LAST) begin
                        // Give up on this request, drop the strobe for one cycle, then re-issue the same PC.
                        err_d      = 1'b1;
                        wdog_cnt_d = 8'd0;
                        retry_d    = 1'b1;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + 8'd1;
                    end
`else
                    if (MEM_ACK) begin
                        ir_d     = MEM_DATA;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
`endif
                end
                S_HOLD: begin
                    if (!STALL) begin
                        valid_d = 1'b0;
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end

        // Strobe is active-low: asserted (0) whenever the next cycle is a live request.
`ifdef FETCH_TIMEOUT_EN
        mem_rd_d = (state_d == S_HOLD) | retry_d;
`else
        mem_rd_d = (state_d == S_HOLD);
`endif
    end

    // State and datapath registers; reset abandons any outstanding request immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            pc_out_q <= 32'd0;
            valid_q  <= 1'b0;
            mem_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            mem_rd_q <= mem_rd_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Watchdog registers; ERR stays set until the next reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wdog_cnt_q <= 8'd0;
            retry_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign MEM_ADDR = pc_q;
    assign MEM_RD   = mem_rd_q;
    assign PC_OUT   = pc_out_q;
    assign VALID    = valid_q;
    assign OPCODE   = ir_q[31:26];
    assign DIR_A    = ir_q[25:21];
    assign DIR_B    = ir_q[20:16];
    assign DIR_WRA  = ir_q[15:11];
    assign IMD      = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for stall/timeout/async reset, then random traffic.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: STALL/MEM_ACK/BR_TAKEN are driven from the bench; all waits are fixed cycle counts.
module tb_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic        STALL;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic [31:0] MEM_DATA;
    logic        MEM_ACK;

    logic [31:0] MEM_ADDR, PC_OUT;
    logic        MEM_RD, VALID, ERR;
    logic [5:0]  OPCODE;
    logic [4:0]  DIR_A, DIR_B, DIR_WRA;
    logic [15:0] IMD;

    logic [31:0] w_addr, w_pc_out;
    logic        w_rd, w_valid, w_err;
    logic [5:0]  w_opcode;
    logic [4:0]  w_dir_a, w_dir_b, w_dir_wra;
    logic [15:0] w_imd;

    localparam int TO = 4;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA), .MEM_ACK(MEM_ACK),
        .PC_OUT(PC_OUT), .OPCODE(OPCODE), .DIR_A(DIR_A), .DIR_B(DIR_B), .DIR_WRA(DIR_WRA),
        .IMD(IMD), .VALID(VALID), .ERR(ERR)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYC(TO)) dut_w (
        .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .MEM_ADDR(w_addr), .MEM_RD(w_rd), .MEM_DATA(MEM_DATA), .MEM_ACK(MEM_ACK),
        .PC_OUT(w_pc_out), .OPCODE(w_opcode), .DIR_A(w_dir_a), .DIR_B(w_dir_b), .DIR_WRA(w_dir_wra),
        .IMD(w_imd), .VALID(w_valid), .ERR(w_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] data;
        logic        e_valid;
        logic        e_rd;
        logic [31:0] e_addr;
        logic [31:0] e_pc_out;
        logic [5:0]  e_opcode;
        logic [15:0] e_imd;
    } vec_t;

    localparam logic [31:0] D1 = 32'h018F_6024;
    localparam logic [31:0] D2 = 32'h2041_0005;

    vec_t vt[16];

    // Reference model state, derived from the fetch rules directly.
    logic [31:0] m_pc, m_ir, m_pc_out;
    bit          m_have, m_err, m_backoff;
    int          m_wait;

    task automatic model_step(input logic st, input logic br, input logic [31:0] tgt,
                              input logic ack, input logic [31:0] dat);
        if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_have = 0; m_wait = 0; m_backoff = 0;
        end else if (m_have) begin
            if (!st) m_have = 0;
        end else begin
`ifdef FETCH_TIMEOUT_EN
            if (m_backoff) begin
                m_backoff = 0;
                m_wait = 0;
            end else if (ack) begin
                m_ir = dat; m_pc_out = m_pc; m_pc = m_pc + 4; m_have = 1; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_err = 1; m_wait = 0; m_backoff = 1;
                end
            end
`else
            if (ack) begin
                m_ir = dat; m_pc_out = m_pc; m_pc = m_pc + 4; m_have = 1;
            end
`endif
        end
    endtask

    initial begin
        vt[0]  = '{0, 0, 32'h0,          1, D1,            1, 1, 32'h4,   32'h0,   6'h00, 16'h6024};
        vt[1]  = '{1, 0, 32'h0,          0, 32'h0,         1, 1, 32'h4,   32'h0,   6'h00, 16'h6024};
        vt[2]  = '{1, 0, 32'h0,          1, 32'hDEADBEEF,  1, 1, 32'h4,   32'h0,   6'h00, 16'h6024};
        vt[3]  = '{1, 0, 32'h0,          0, 32'h0,         1, 1, 32'h4,   32'h0,   6'h00, 16'h6024};
        vt[4]  = '{1, 0, 32'h0,          1, 32'h12345678,  1, 1, 32'h4,   32'h0,   6'h00, 16'h6024};
        vt[5]  = '{1, 0, 32'h0,          0, 32'h0,         1, 1, 32'h4,   32'h0,   6'h00, 16'h6024};
        vt[6]  = '{0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h4,   32'h0,   6'h00, 16'h6024};
        vt[7]  = '{0, 0, 32'h0,          1, D2,            1, 1, 32'h8,   32'h4,   6'h08, 16'h0005};
        vt[8]  = '{1, 0, 32'h0,          0, 32'h0,         1, 1, 32'h8,   32'h4,   6'h08, 16'h0005};
        vt[9]  = '{0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h8,   32'h4,   6'h08, 16'h0005};
        vt[10] = '{1, 0, 32'h0,          0, 32'h0,         0, 0, 32'h8,   32'h4,   6'h08, 16'h0005};
        vt[11] = '{0, 1, 32'h0000_0103,  1, 32'hFFFFFFFF,  0, 0, 32'h100, 32'h4,   6'h08, 16'h0005};
        vt[12] = '{0, 0, 32'h0,          1, D1,            1, 1, 32'h104, 32'h100, 6'h00, 16'h6024};
        vt[13] = '{1, 1, 32'h0000_0201,  0, 32'h0,         0, 0, 32'h200, 32'h100, 6'h00, 16'h6024};
        vt[14] = '{0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h200, 32'h100, 6'h00, 16'h6024};
        vt[15] = '{0, 0, 32'h0,          1, 32'hFC00_0000, 1, 1, 32'h204, 32'h200, 6'h3F, 16'h0000};

        STALL = 0; BR_TAKEN = 0; BR_TARGET = 0; MEM_ACK = 0; MEM_DATA = 0;
        RST_N = 0;

        // Reset held for three cycles, with an ACK present that must be ignored.
        MEM_ACK = 1; MEM_DATA = D1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_valid",   {31'd0, VALID},  32'd0);
        chk("rst_rd",      {31'd0, MEM_RD}, 32'd0);
        chk("rst_addr",    MEM_ADDR,        32'h0);
        chk("rst_pc_out",  PC_OUT,          32'h0);
        chk("rst_err",     {31'd0, ERR},    32'd0);
        chk("rst_ir",      {OPCODE, DIR_A, DIR_B, IMD}, 32'h0);
        chk("rst_w_addr",  w_addr,          32'hFFFF_FFFC);
        MEM_ACK = 0;
        RST_N = 1;

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            STALL = vt[i].stall; BR_TAKEN = vt[i].br; BR_TARGET = vt[i].tgt;
            MEM_ACK = vt[i].ack; MEM_DATA = vt[i].data;
            tick();
            chk($sformatf("vec%0d_valid", i),  {31'd0, VALID},  {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_rd", i),     {31'd0, MEM_RD}, {31'd0, vt[i].e_rd});
            chk($sformatf("vec%0d_addr", i),   MEM_ADDR,        vt[i].e_addr);
            chk($sformatf("vec%0d_pc_out", i), PC_OUT,          vt[i].e_pc_out);
            chk($sformatf("vec%0d_opcode", i), {26'd0, OPCODE}, {26'd0, vt[i].e_opcode});
            chk($sformatf("vec%0d_imd", i),    {16'd0, IMD},    {16'd0, vt[i].e_imd});
            if (i == 0) begin
                chk("f0_dir_a",   {27'd0, DIR_A},   32'd12);
                chk("f0_dir_b",   {27'd0, DIR_B},   32'd15);
                chk("f0_dir_wra", {27'd0, DIR_WRA}, 32'd12);
                chk("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
                chk("wrap_addr",   w_addr,   32'h0);
            end
        end
        STALL = 0; BR_TAKEN = 0; MEM_ACK = 0;

        // Release hold, then starve the request of ACK.
        tick();
        chk("starve_enter_rd", {31'd0, MEM_RD}, 32'd0);
`ifdef FETCH_TIMEOUT_EN
        for (int c = 1; c <= TO + 1; c++) begin
            tick();
            chk($sformatf("to%0d_err", c),  {31'd0, ERR},    {31'd0, (c >= TO)});
            chk($sformatf("to%0d_rd", c),   {31'd0, MEM_RD}, {31'd0, (c == TO)});
            chk($sformatf("to%0d_addr", c), MEM_ADDR,        32'h204);
        end
`else
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("noto%0d_err", c),  {31'd0, ERR},    32'd0);
            chk($sformatf("noto%0d_rd", c),   {31'd0, MEM_RD}, 32'd0);
            chk($sformatf("noto%0d_addr", c), MEM_ADDR,        32'h204);
        end
`endif
        MEM_ACK = 1; MEM_DATA = D2;
        tick();
        MEM_ACK = 0;
        chk("pre_arst_valid", {31'd0, VALID}, 32'd1);
        chk("pre_arst_pc_out", PC_OUT, 32'h204);

        // Asynchronous reset between edges while VALID is high.
        #2;
        RST_N = 0;
        #1;
        chk("arst_valid",  {31'd0, VALID},  32'd0);
        chk("arst_addr",   MEM_ADDR,        32'h0);
        chk("arst_rd",     {31'd0, MEM_RD}, 32'd0);
        chk("arst_pc_out", PC_OUT,          32'h0);
        chk("arst_err",    {31'd0, ERR},    32'd0);
        MEM_ACK = 1; MEM_DATA = D1;
        tick();
        chk("arst_ack_ignored", {31'd0, VALID}, 32'd0);
        MEM_ACK = 0;
        RST_N = 1;
        #1;
        chk("post_rst_addr", MEM_ADDR, 32'h0);

        // Random traffic against the reference model.
        m_pc = 32'h0; m_ir = 32'h0; m_pc_out = 32'h0;
        m_have = 0; m_err = 0; m_backoff = 0; m_wait = 0;
        for (int n = 0; n < 1500; n++) begin
            STALL     = ($urandom_range(99, 0) < 40);
            BR_TAKEN  = ($urandom_range(99, 0) < 8);
            BR_TARGET = $urandom;
            MEM_ACK   = ($urandom_range(99, 0) < 55);
            MEM_DATA  = $urandom;
            @(posedge CLK);
            model_step(STALL, BR_TAKEN, BR_TARGET, MEM_ACK, MEM_DATA);
            #1;
            chk("rnd_valid",  {31'd0, VALID},  {31'd0, m_have});
            chk("rnd_rd",     {31'd0, MEM_RD}, {31'd0, (m_have | m_backoff)});
            chk("rnd_addr",   MEM_ADDR,        m_pc);
            chk("rnd_pc_out", PC_OUT,          m_pc_out);
            chk("rnd_ir",     {OPCODE, DIR_A, DIR_B, IMD}, m_ir);
            chk("rnd_wra",    {27'd0, DIR_WRA}, {27'd0, m_ir[15:11]});
            chk("rnd_err",    {31'd0, ERR},    {31'd0, m_err});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: wait-cycle limit for the FETCH_TIMEOUT_EN watchdog, range 1..255.
REQ-003 SHALL have port CLK  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port STALL  in  1: 1 means decode cannot accept; hold current instruction.
REQ-006 SHALL have port BR_TAKEN  in  1: redirect request from execute.
REQ-007 SHALL have port BR_TARGET  in  32: redirect address.
REQ-008 SHALL have port MEM_ADDR  out  32: instruction memory address.
REQ-009 SHALL have port MEM_RD  out  1: memory read strobe, active-low, same polarity as decode REG_RD.
REQ-010 SHALL have port MEM_DATA  in  32: instruction word from memory.
REQ-011 SHALL have port MEM_ACK  in  1: 1 means MEM_DATA is valid this cycle.
REQ-012 SHALL have port PC_OUT  out  32: address of the instruction held in the instruction register (IR).
REQ-013 SHALL have port OPCODE  out  6: IR[31:26].
REQ-014 SHALL have port DIR_A  out  5: IR[25:21], driven to decode DIR_A.
REQ-015 SHALL have port DIR_B  out  5: IR[20:16], driven to decode DIR_B.
REQ-016 SHALL have port DIR_WRA  out  5: IR[15:11], driven to decode DIR_WRA.
REQ-017 SHALL have port IMD  out  16: IR[15:0], driven to decode IMD.
REQ-018 SHALL have port VALID  out  1: 1 means the IR fields are a live instruction.
REQ-019 SHALL have port ERR  out  1: sticky fetch-timeout flag.

Function
REQ-020 SHALL implement a 2-state FSM: S_REQ and S_HOLD.
REQ-021 In S_REQ, SHALL drive MEM_RD=0 and MEM_ADDR=PC; MEM_RD=1 in S_HOLD.
REQ-022 In S_REQ with MEM_ACK=1 and BR_TAKEN=0, SHALL on the same edge:
- load IR<=MEM_DATA and PC_OUT<=PC;
- set PC<=PC+4, with modulo-2^32 wrap (32'hFFFF_FFFC+4 -> 0);
- set VALID<=1 and go to S_HOLD.
- Latency, MEM_ACK edge to VALID high: 1 cycle.
REQ-023 In S_HOLD with STALL=1, SHALL hold IR, PC_OUT, VALID and all field outputs unchanged.
REQ-024 In S_HOLD with STALL=0, SHALL clear VALID and go to S_REQ on the next edge.
REQ-025 BR_TAKEN=1 in any state SHALL override all other inputs:
- PC<={BR_TARGET[31:2],2'b00};
- VALID<=0 and state<=S_REQ;
- any MEM_ACK/MEM_DATA in the same cycle is discarded.
REQ-026 STALL SHALL be ignored in S_REQ; MEM_ACK SHALL be ignored in S_HOLD.
REQ-027 Field outputs SHALL be pure combinational slices of IR; IR SHALL change only per REQ-022 and reset.

Reset
REQ-028 RST_N=0 SHALL asynchronously set:
- PC=RESET_PC; IR=0; PC_OUT=0; VALID=0; ERR=0;
- watchdog count=0; state=S_REQ.
- Consequently MEM_RD=0 and MEM_ADDR=RESET_PC during reset.
REQ-029 RST_N asserted mid-request SHALL abandon the request; a MEM_ACK arriving while RST_N=0 SHALL be ignored.
REQ-030 The first request after RST_N deasserts SHALL target RESET_PC.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN, when defined, SHALL include an 8-bit watchdog:
- counts S_REQ cycles without MEM_ACK;
- on reaching TIMEOUT_CYC: set ERR=1 (sticky until reset), clear count, deassert MEM_RD for 1 cycle, then re-issue the same PC;
- count clears on MEM_ACK, BR_TAKEN, or leaving S_REQ.
REQ-032 Without FETCH_TIMEOUT_EN, SHALL have no watchdog logic: ERR is tied 0 and S_REQ waits indefinitely.

Verification
REQ-033 Reset then sequential fetch: RST_N low 3 cycles, then ACK each request with MEM_DATA=32'h018F6024 -> first MEM_ADDR=0, next 4:
- VALID 1 cycle after ACK;
- DIR_A=12, DIR_B=15, DIR_WRA=12, IMD=16'h6024, OPCODE=0, PC_OUT=0.
REQ-034 Stall: VALID=1, STALL=1 for 5 cycles -> IR/PC_OUT frozen, MEM_RD=1 throughout; STALL=0 -> VALID=0 and MEM_RD=0 next cycle, MEM_ADDR=8.
REQ-035 Branch collision: BR_TAKEN=1 with BR_TARGET=32'h0000_0103 in the same cycle as MEM_ACK -> data dropped, VALID stays 0, next MEM_ADDR=32'h0000_0100.
REQ-036 Wrap: RESET_PC=32'hFFFF_FFFC, ACK first fetch -> PC_OUT=32'hFFFF_FFFC, next MEM_ADDR=0.
REQ-037 Timeout with FETCH_TIMEOUT_EN defined and TIMEOUT_CYC=4, MEM_ACK held 0 -> ERR=1 after 4 S_REQ cycles, MEM_RD=1 one cycle, re-request same address; without the macro, ERR stays 0 and MEM_RD stays 0.
REQ-038 Reset mid-operation: pull RST_N low asynchronously between edges while VALID=1 -> VALID=0 and PC=RESET_PC immediately, without waiting for a CLK edge.
